// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
//   Sweeps every input combination of an N_IN-input combinational block in
//   ascending binary order. For each vector it waits SETTLE cycles, then
//   compares the block's response with a golden response. It reports the
//   mismatch count, the first failing vector and an overall pass flag.
//
//   Optional build macro: TT_CAPTURE_EN
//     When defined, an extra output port `capture` holds the observed truth
//     table. Vector v occupies bits [v*N_OUT +: N_OUT].
//
//   Timing: from the start-accept edge to the done pulse takes exactly
//   2**N_IN*(SETTLE+1) cycles. busy stays high up to and including the done
//   cycle. pass becomes valid together with done.
module truth_table_sweeper #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 1,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic [N_OUT-1:0]  dut_out,
  input  logic [N_OUT-1:0]  exp_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic [N_IN-1:0]   first_fail,
  output logic              first_fail_vld
`ifdef TT_CAPTURE_EN
  ,
  output logic [(2**N_IN)*N_OUT-1:0] capture
`endif
);

  // Sweep-wide constants
  localparam logic [7:0]        SETTLE_C   = 8'(SETTLE);
  localparam logic [7:0]        CNT_ONE    = 8'd1;
  localparam logic [7:0]        CNT_ZERO   = 8'd0;
  localparam logic [N_IN-1:0]   STIM_LAST  = {N_IN{1'b1}};
  localparam logic [N_IN-1:0]   STIM_ZERO  = {N_IN{1'b0}};
  localparam logic [N_IN-1:0]   STIM_ONE   = {{(N_IN-1){1'b0}}, 1'b1};
  localparam logic [N_IN:0]     ERR_ZERO   = {(N_IN+1){1'b0}};
`ifdef TT_CAPTURE_EN
  localparam int                CAP_W      = (2**N_IN)*N_OUT;
  localparam logic [CAP_W-1:0]  CAP_ZERO   = {CAP_W{1'b0}};
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic [N_IN-1:0]     stim_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic [N_IN:0]       err_cnt_q;
  logic [N_IN-1:0]     first_fail_q;
  logic                first_fail_vld_q;
`ifdef TT_CAPTURE_EN
  logic [CAP_W-1:0]    capture_q;
`endif

  logic                mismatch_d;
  logic [N_IN:0]       err_cnt_d;

  // Per-vector comparison and the error count that includes this vector
  always_comb begin
    mismatch_d = 1'b0;
    err_cnt_d  = err_cnt_q;
    if (dut_out != exp_out) begin
      mismatch_d = 1'b1;
    end else begin
      mismatch_d = 1'b0;
    end
    err_cnt_d = err_cnt_q + {{N_IN{1'b0}}, mismatch_d};
  end

  // Sweep controller: state, counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= CNT_ZERO;
      stim_q           <= STIM_ZERO;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      err_cnt_q        <= ERR_ZERO;
      first_fail_q     <= STIM_ZERO;
      first_fail_vld_q <= 1'b0;
`ifdef TT_CAPTURE_EN
      capture_q        <= CAP_ZERO;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            // New sweep: clear all results, drive vector 0
            stim_q           <= STIM_ZERO;
            cnt_q            <= SETTLE_C;
            err_cnt_q        <= ERR_ZERO;
            first_fail_q     <= STIM_ZERO;
            first_fail_vld_q <= 1'b0;
            pass_q           <= 1'b0;
            busy_q           <= 1'b1;
`ifdef TT_CAPTURE_EN
            capture_q        <= CAP_ZERO;
`endif
            state_q          <= S_SETTLE;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_SETTLE: begin
          // The counter is loaded with SETTLE, so this state lasts SETTLE cycles
          if (cnt_q <= CNT_ONE) begin
            cnt_q   <= CNT_ZERO;
            state_q <= S_CHECK;
          end else begin
            cnt_q   <= cnt_q - CNT_ONE;
            state_q <= S_SETTLE;
          end
        end

        S_CHECK: begin
          err_cnt_q <= err_cnt_d;
          if (mismatch_d && !first_fail_vld_q) begin
            first_fail_q     <= stim_q;
            first_fail_vld_q <= 1'b1;
          end else begin
            first_fail_q     <= first_fail_q;
            first_fail_vld_q <= first_fail_vld_q;
          end
`ifdef TT_CAPTURE_EN
          capture_q[int'(stim_q)*N_OUT +: N_OUT] <= dut_out;
`endif
          if (stim_q == STIM_LAST) begin
            // Last vector: the verdict uses the count including this check
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == ERR_ZERO);
            state_q <= S_DONE;
          end else begin
            stim_q  <= stim_q + STIM_ONE;
            cnt_q   <= SETTLE_C;
            state_q <= S_SETTLE;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stim           = stim_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_fail     = first_fail_q;
  assign first_fail_vld = first_fail_vld_q;
`ifdef TT_CAPTURE_EN
  assign capture        = capture_q;
`endif

endmodule
